ctrl_sequencer: RTL
===================

CTRL_SEQUENCER -- requirements
Module: ctrl_sequencer

Interface
REQ-001 SHALL have parameter NREG, default 2, legal range 1..8: number of loadable general registers.
REQ-002 SHALL have parameter MAX_WAIT, default 15, legal range 1..255: maximum cycles spent waiting on alu_ready.
REQ-003 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port run  input  1  level; high allows instruction cycles to start.
REQ-006 SHALL have port instr  input  8  current instruction; opcode instr[7:4], operand instr[3:0].
REQ-007 SHALL have port flag_bit  input  1  shifter flag.
REQ-008 SHALL have port alu_ready  input  1  ALU completion handshake.
REQ-009 SHALL have outputs ir_en, pc_inc, pc_load, out_we, alu_en, clr_acc, each 1 bit: one-cycle strobes.
REQ-010 SHALL have output reg_we  NREG bits  one-hot register load strobe.
REQ-011 SHALL have output pc_target  4 bits  jump address; output sh_mode  2 bits  shifter command (00 hold, 01 right, 10 left, 11 load).
REQ-012 SHALL have output mux_sel  2 bits  operand source; output alu_op  4 bits  ALU function.
REQ-013 SHALL have output phase  4 bits  one-hot state (T0=1000, T1=0100, T2=0010, T3=0001, 0000 otherwise); output busy  1 bit; output timeout  1 bit, sticky.

Function
REQ-014 SHALL implement states IDLE, T0 (fetch), T1 (decode), T2 (execute), WAIT, T3 (advance).
REQ-015 SHALL go IDLE->T0 on the first edge where run=1; T0->T1->T2 unconditionally; T2->WAIT for ALU opcodes, else T2->T3; T3->T0 if run=1, else T3->IDLE.
REQ-016 SHALL register all outputs; every strobe is high exactly in the cycle in which phase shows its state; ir_en in T0; pc_inc or pc_load in T3; reg_we, out_we, alu_en, clr_acc and non-00 sh_mode in T2.
REQ-017 SHALL latch opcode, operand and flag_bit in T1; changes to instr or flag_bit after T1 have no effect on the current instruction.
REQ-018 SHALL decode: 0 LDR reg_we[operand]=1; 1 OUT out_we; 2 LDSH sh_mode=11, mux_sel=operand[1:0]; 3 SHR sh_mode=01; 4 SHL sh_mode=10.
REQ-019 SHALL decode ALU opcodes with alu_op: 5 ADDF 0011 only if latched flag=1, mux_sel=operand[1:0]; 6 ADD 0011; 7 SUB 0100; 8 NOT 0110; 9 AND 0000; A OR 0001; B XOR 0010.
REQ-020 SHALL decode: C JMP pc_load, pc_target=operand; D JF as JMP only if latched flag=1, else pc_inc; E NOP; F CLR clr_acc.
REQ-021 SHALL treat ADDF with flag=0 as NOP: no alu_en, no WAIT.
REQ-022 SHALL treat LDR with operand>=NREG as NOP.
REQ-023 SHALL hold alu_op and mux_sel at their last driven value between instructions; all other outputs return to 0 outside their strobe cycle.
REQ-024 SHALL assert pc_inc in T3 for every opcode except a taken jump; pc_inc and pc_load are never both high.
REQ-025 SHALL, in WAIT, go to T3 on the first cycle alu_ready=1; alu_ready in T2 is ignored, so WAIT lasts at least 1 cycle.
REQ-026 SHALL count WAIT cycles; if MAX_WAIT cycles pass without alu_ready, set timeout=1 and go to T3.
REQ-027 SHALL keep timeout at 1 until reset.
REQ-028 SHALL keep busy=1 in every state except IDLE.
REQ-029 SHALL complete the current instruction when run falls mid-instruction; run affects transitions only in IDLE and T3.

Reset
REQ-030 SHALL, while rst=1, force state IDLE, phase=0000, busy=0, timeout=0, WAIT counter=0, all strobes 0, reg_we=0, sh_mode=00, mux_sel=00, pc_target=0, alu_op=1111, clr_acc=1.
REQ-031 SHALL deassert clr_acc on the first clock edge after rst falls.
REQ-032 SHALL abandon any in-flight instruction on reset, including in WAIT, with no further strobe.

Verification
REQ-033 Reset, then run=1, instr=0x01, NREG=2 -> phases 1000,0100,0010,0001; reg_we=10 in T2; pc_inc in T3; clr_acc 1->0 on the first edge.
REQ-034 instr=0x62, alu_ready high 3 cycles after T2 -> alu_op=0011, alu_en one cycle, WAIT 3 cycles, then T3 pc_inc; total 7 cycles.
REQ-035 instr=0x50, flag=0 -> no alu_en, no WAIT; repeat with flag=1 -> alu_en, alu_op=0011, mux_sel=00.
REQ-036 instr=0xD9: flag=1 -> pc_load, pc_target=9, no pc_inc; flag=0 -> pc_inc only.
REQ-037 MAX_WAIT=4, instr=0x70, alu_ready held 0 -> T3 after 4 WAIT cycles, timeout=1 and stays 1 through later instructions.
REQ-038 run dropped in T1 of instr=0x40 -> sh_mode=10 in T2, T3, then IDLE with busy=0; rst asserted in WAIT -> all outputs at reset values immediately.

Source files
------------

// File: rtl/ctrl_sequencer.sv
// Four-phase instruction sequencer: fetch, decode, execute (with optional ALU wait), advance.
// All outputs are registered so each strobe lines up with the phase that announces it.
module ctrl_sequencer #(
   parameter int NREG     = 2,
   parameter int MAX_WAIT = 15
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            run,
   input  logic [7:0]      instr,
   input  logic            flag_bit,
   input  logic            alu_ready,
   output logic            ir_en,
   output logic            pc_inc,
   output logic            pc_load,
   output logic            out_we,
   output logic            alu_en,
   output logic            clr_acc,
   output logic [NREG-1:0] reg_we,
   output logic [3:0]      pc_target,
   output logic [1:0]      sh_mode,
   output logic [1:0]      mux_sel,
   output logic [3:0]      alu_op,
   output logic [3:0]      phase,
   output logic            busy,
   output logic            timeout
);

   typedef enum logic [2:0] {S_IDLE, S_T0, S_T1, S_T2, S_WAIT, S_T3} state_t;

   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

   state_t state, state_d;
   logic [7:0] wait_cnt, wait_cnt_d;
   logic [3:0] op_q, opnd_q;
   logic       flag_q;
   logic       enter_t3;

   logic            ir_en_d, pc_inc_d, pc_load_d, out_we_d, alu_en_d, clr_acc_d, timeout_d;
   logic [NREG-1:0] reg_we_d;
   logic [3:0]      pc_target_d, alu_op_d;
   logic [1:0]      sh_mode_d, mux_sel_d;

   function automatic logic [3:0] phase_of(input state_t s);
      case (s)
         S_T0:    phase_of = 4'b1000;
         S_T1:    phase_of = 4'b0100;
         S_T2:    phase_of = 4'b0010;
         S_T3:    phase_of = 4'b0001;
         default: phase_of = 4'b0000;
      endcase
   endfunction

   function automatic logic is_alu(input logic [3:0] op, input logic fl);
      is_alu = (op == 4'h5) ? fl : (op >= 4'h6 && op <= 4'hB);
   endfunction

   function automatic logic jump_taken(input logic [3:0] op, input logic fl);
      jump_taken = (op == 4'hC) || (op == 4'hD && fl);
   endfunction

   // Instruction fields are captured at the end of T1 and drive T2..T3 decisions.
   always_ff @(posedge clk) begin
      if (state == S_T1) begin
         op_q   <= instr[7:4];
         opnd_q <= instr[3:0];
         flag_q <= flag_bit;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         wait_cnt  <= '0;
         ir_en     <= 1'b0;
         pc_inc    <= 1'b0;
         pc_load   <= 1'b0;
         out_we    <= 1'b0;
         alu_en    <= 1'b0;
         clr_acc   <= 1'b1;
         reg_we    <= '0;
         pc_target <= '0;
         sh_mode   <= 2'b00;
         mux_sel   <= 2'b00;
         alu_op    <= 4'b1111;
         phase     <= 4'b0000;
         busy      <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         state     <= state_d;
         wait_cnt  <= wait_cnt_d;
         ir_en     <= ir_en_d;
         pc_inc    <= pc_inc_d;
         pc_load   <= pc_load_d;
         out_we    <= out_we_d;
         alu_en    <= alu_en_d;
         clr_acc   <= clr_acc_d;
         reg_we    <= reg_we_d;
         pc_target <= pc_target_d;
         sh_mode   <= sh_mode_d;
         mux_sel   <= mux_sel_d;
         alu_op    <= alu_op_d;
         phase     <= phase_of(state_d);
         busy      <= (state_d != S_IDLE);
         timeout   <= timeout_d;
      end
   end

   always_comb begin
      state_d     = state;
      wait_cnt_d  = wait_cnt;
      timeout_d   = timeout;
      enter_t3    = 1'b0;
      ir_en_d     = 1'b0;
      pc_inc_d    = 1'b0;
      pc_load_d   = 1'b0;
      out_we_d    = 1'b0;
      alu_en_d    = 1'b0;
      clr_acc_d   = 1'b0;
      reg_we_d    = '0;
      pc_target_d = 4'h0;
      sh_mode_d   = 2'b00;
      mux_sel_d   = mux_sel;
      alu_op_d    = alu_op;

      case (state)
         S_IDLE: begin
            if (run) begin
               state_d = S_T0;
               ir_en_d = 1'b1;
            end
         end
         S_T0: state_d = S_T1;
         // Decode from live instr so execute strobes appear in the T2 cycle itself.
         S_T1: begin
            state_d = S_T2;
            case (instr[7:4])
               4'h0: if (32'(instr[3:0]) < NREG) reg_we_d = NREG'(1) << instr[3:0];
               4'h1: out_we_d = 1'b1;
               4'h2: begin
                  sh_mode_d = 2'b11;
                  mux_sel_d = instr[1:0];
               end
               4'h3: sh_mode_d = 2'b01;
               4'h4: sh_mode_d = 2'b10;
               4'h5: begin
                  if (flag_bit) begin
                     alu_en_d  = 1'b1;
                     alu_op_d  = 4'b0011;
                     mux_sel_d = instr[1:0];
                  end
               end
               4'h6: begin alu_en_d = 1'b1; alu_op_d = 4'b0011; end
               4'h7: begin alu_en_d = 1'b1; alu_op_d = 4'b0100; end
               4'h8: begin alu_en_d = 1'b1; alu_op_d = 4'b0110; end
               4'h9: begin alu_en_d = 1'b1; alu_op_d = 4'b0000; end
               4'hA: begin alu_en_d = 1'b1; alu_op_d = 4'b0001; end
               4'hB: begin alu_en_d = 1'b1; alu_op_d = 4'b0010; end
               4'hF: clr_acc_d = 1'b1;
               default: ;
            endcase
         end
         S_T2: begin
            if (is_alu(op_q, flag_q)) begin
               state_d    = S_WAIT;
               wait_cnt_d = '0;
            end else begin
               enter_t3 = 1'b1;
            end
         end
         S_WAIT: begin
            if (alu_ready) begin
               enter_t3 = 1'b1;
            end else if (wait_cnt == WAIT_LAST) begin
               enter_t3  = 1'b1;
               timeout_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt + 8'd1;
            end
         end
         S_T3: begin
            if (run) begin
               state_d = S_T0;
               ir_en_d = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (enter_t3) begin
         state_d = S_T3;
         if (jump_taken(op_q, flag_q)) begin
            pc_load_d   = 1'b1;
            pc_target_d = opnd_q;
         end else begin
            pc_inc_d = 1'b1;
         end
      end
   end

endmodule
